// File: rtl/tdes_ahb_pkg.sv
// Shared bus constants, register map and state types for the TDES AHB-Lite initiator.
package tdes_ahb_pkg;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [2:0] HsizeDword   = 3'b011;
  localparam logic [2:0] HburstSingle = 3'b000;
  localparam logic [3:0] HprotData    = 4'b0011;

  localparam logic [7:0] OffData   = 8'h00;
  localparam logic [7:0] OffKey1   = 8'h08;
  localparam logic [7:0] OffKey2   = 8'h10;
  localparam logic [7:0] OffKey3   = 8'h18;
  localparam logic [7:0] OffCtrl   = 8'h20;
  localparam logic [7:0] OffStatus = 8'h28;
  localparam logic [7:0] OffResult = 8'h30;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_type;

  typedef enum logic [2:0] {
    StepKey1, StepKey2, StepKey3, StepData, StepCtrl, StepStatus, StepResult
  } step_type;

  function automatic logic [7:0] step_offset(step_type step);
    logic [7:0] off;
    case (step)
      StepKey1:   off = OffKey1;
      StepKey2:   off = OffKey2;
      StepKey3:   off = OffKey3;
      StepData:   off = OffData;
      StepCtrl:   off = OffCtrl;
      StepStatus: off = OffStatus;
      StepResult: off = OffResult;
      default:    off = OffData;
    endcase
    return off;
  endfunction

  function automatic logic step_is_write(step_type step);
    return !(step inside {StepStatus, StepResult});
  endfunction

endpackage

// File: rtl/tdes_ahb_xfer.sv
// Single-transfer AHB-Lite engine: address phase, data phase, wait states and ERROR response,
// plus the job handshake/result pulse. The sequencer above supplies the next address.
module tdes_ahb_xfer
  import tdes_ahb_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic [31:0] nxt_addr,
  input  logic        nxt_write,
  input  logic [63:0] cur_wdata,
  input  logic        seq_end,
  input  logic        seq_fail,
  output logic        advance,
  output logic        job_ready,
  output logic        res_valid,
  output logic        res_error,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [63:0] HWDATA
);

  state_type state_q;

  assign HSIZE     = HsizeDword;
  assign HBURST    = HburstSingle;
  assign HPROT     = HprotData;
  assign HMASTLOCK = 1'b0;

  // Successful completion of the current data phase.
  assign advance = (state_q == StData) & HREADY & ~HRESP;

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q   <= StIdle;
      HTRANS    <= HtransIdle;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
      job_ready <= 1'b1;
      res_valid <= 1'b0;
      res_error <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StAddr;
            HTRANS    <= HtransNonseq;
            HADDR     <= nxt_addr;
            HWRITE    <= nxt_write;
            job_ready <= 1'b0;
          end
        end
        StAddr: begin
          if (HREADY) begin
            state_q <= StData;
            HTRANS  <= HtransIdle;
            HWDATA  <= cur_wdata;
          end
        end
        StData: begin
          // ERROR is taken on its first cycle; no further transfer is issued.
          if (HRESP) begin
            state_q   <= StDone;
            res_valid <= 1'b1;
            res_error <= 1'b1;
          end else if (HREADY) begin
            if (seq_end) begin
              state_q   <= StDone;
              res_valid <= 1'b1;
              res_error <= seq_fail;
            end else begin
              state_q <= StAddr;
              HTRANS  <= HtransNonseq;
              HADDR   <= nxt_addr;
              HWRITE  <= nxt_write;
            end
          end
        end
        StDone: begin
          state_q   <= StIdle;
          res_valid <= 1'b0;
          job_ready <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/tdes_ahb_master.sv
// AHB-Lite initiator running one Triple-DES job on the TDES slave: writes keys/data/control,
// polls STATUS, reads RESULT. Optional STATUS poll timeout: define TDES_POLL_TIMEOUT_EN.
module tdes_ahb_master
  import tdes_ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hAAAAAA00
`ifdef TDES_POLL_TIMEOUT_EN
  ,
  parameter logic [15:0] POLL_LIMIT = 16'd1024
`endif
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic        job_encrypt,
  input  logic [63:0] job_data,
  input  logic [63:0] job_key1,
  input  logic [63:0] job_key2,
  input  logic [63:0] job_key3,
  output logic        res_valid,
  output logic [63:0] res_data,
  output logic        res_error,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [63:0] HRDATA,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [63:0] HWDATA
);

  logic [63:0] key1_q, key2_q, key3_q, data_q;
  logic        encrypt_q;
  step_type    step_q, nxt_step;
  logic        accept, advance, seq_end, seq_fail, poll_expired;
  logic [31:0] nxt_addr;
  logic        nxt_write;
  logic [63:0] cur_wdata;

  assign accept = job_valid & job_ready;

`ifdef TDES_POLL_TIMEOUT_EN
  logic [15:0] poll_cnt_q;

  // Counts completed STATUS reads; the current read is number poll_cnt_q + 1.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      poll_cnt_q <= '0;
    end else if (accept) begin
      poll_cnt_q <= '0;
    end else if (advance && (step_q == StepStatus)) begin
      poll_cnt_q <= poll_cnt_q + 16'd1;
    end
  end

  assign poll_expired = ({1'b0, poll_cnt_q} + 17'd1) >= {1'b0, POLL_LIMIT};
`else
  assign poll_expired = 1'b0;
`endif

  always_comb begin
    nxt_step = step_q;
    seq_end  = 1'b0;
    seq_fail = 1'b0;
    if (job_ready) begin
      nxt_step = StepKey1;
    end else begin
      unique case (step_q)
        StepKey1: nxt_step = StepKey2;
        StepKey2: nxt_step = StepKey3;
        StepKey3: nxt_step = StepData;
        StepData: nxt_step = StepCtrl;
        StepCtrl: nxt_step = StepStatus;
        StepStatus: begin
          if (HRDATA[0]) begin
            nxt_step = StepResult;
          end else if (poll_expired) begin
            seq_end  = 1'b1;
            seq_fail = 1'b1;
          end
        end
        StepResult: seq_end = 1'b1;
        default:    seq_end = 1'b1;
      endcase
    end
  end

  assign nxt_addr  = BASE_ADDR + {24'h0, step_offset(nxt_step)};
  assign nxt_write = step_is_write(nxt_step);

  always_comb begin
    cur_wdata = '0;
    unique case (step_q)
      StepKey1: cur_wdata = key1_q;
      StepKey2: cur_wdata = key2_q;
      StepKey3: cur_wdata = key3_q;
      StepData: cur_wdata = data_q;
      StepCtrl: cur_wdata = {62'h0, encrypt_q, 1'b1};
      default:  cur_wdata = '0;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      key1_q    <= '0;
      key2_q    <= '0;
      key3_q    <= '0;
      data_q    <= '0;
      encrypt_q <= 1'b0;
      step_q    <= StepKey1;
      res_data  <= '0;
    end else if (accept) begin
      key1_q    <= job_key1;
      key2_q    <= job_key2;
      key3_q    <= job_key3;
      data_q    <= job_data;
      encrypt_q <= job_encrypt;
      step_q    <= StepKey1;
    end else if (advance) begin
      step_q <= nxt_step;
      if (step_q == StepResult) res_data <= HRDATA;
    end
  end

  tdes_ahb_xfer u_xfer (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .start     (accept),
    .nxt_addr  (nxt_addr),
    .nxt_write (nxt_write),
    .cur_wdata (cur_wdata),
    .seq_end   (seq_end),
    .seq_fail  (seq_fail),
    .advance   (advance),
    .job_ready (job_ready),
    .res_valid (res_valid),
    .res_error (res_error),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HMASTLOCK (HMASTLOCK),
    .HWDATA    (HWDATA)
  );

endmodule
